// File: rtl/jtag_cmd_bridge.sv
// jtag_cmd_bridge
//   Command layer that sits on the usb_jtag byte link. It collects received
//   bytes into write/read frames, performs one single-beat access on a simple
//   on-chip bus, and sends back an ack byte, an error byte or the read data
//   over the link's transmit handshake.
//
//   Frames (multi-byte fields are sent LSB byte first):
//     write : 8'h57, NA address bytes, ND data bytes -> bus write, reply ACK_BYTE
//     read  : 8'h52, NA address bytes -> bus read, reply ND data bytes LSB first
//     Any other first byte is dropped and the bridge stays idle.
//
// Ports
//   iCLK, iRST_n            clock (rising edge), asynchronous active-low reset
//   iRxD_DATA, iRxD_Ready   received byte and its one-cycle valid pulse
//   oTxD_DATA, oTxD_Start   byte to send; Start is held high until iTxD_Done
//   iTxD_Done               one-cycle pulse when the link has sent the byte
//   oBUS_ADDR, oBUS_WDATA   access address and write data (kept after a frame)
//   oBUS_WR, oBUS_RD        one-cycle write / read strobes
//   iBUS_RDATA, iBUS_RDVALID read data and its one-cycle valid pulse
//   oBUSY                   high whenever a frame or reply is in progress
module jtag_cmd_bridge #(
  parameter int         ADDR_W   = 16,
  parameter int         DATA_W   = 32,
  parameter int         TIMEOUT  = 1000000,
  parameter logic [7:0] ACK_BYTE = 8'hAA,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [7:0]        iRxD_DATA,
  input  logic              iRxD_Ready,
  output logic [7:0]        oTxD_DATA,
  output logic              oTxD_Start,
  input  logic              iTxD_Done,
  output logic [ADDR_W-1:0] oBUS_ADDR,
  output logic [DATA_W-1:0] oBUS_WDATA,
  output logic              oBUS_WR,
  output logic              oBUS_RD,
  input  logic [DATA_W-1:0] iBUS_RDATA,
  input  logic              iBUS_RDVALID,
  output logic              oBUSY
);

  localparam int         NA        = ADDR_W / 8;
  localparam int         ND        = DATA_W / 8;
  localparam logic [7:0] OP_WR     = 8'h57;
  localparam logic [7:0] OP_RD     = 8'h52;
  localparam logic [7:0] ADDR_LAST = 8'(NA - 1);
  localparam logic [7:0] DATA_LAST = 8'(ND - 1);
  localparam logic [7:0] RD_BYTES  = 8'(ND);
  localparam int         TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS_WR,
    S_BUS_RD,
    S_WAIT_RD,
    S_TX_LOAD,
    S_TX_WAIT,
    S_TX_GAP
  } state_t;

  state_t              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   txbuf_q, txbuf_d;
  logic [7:0]          rem_q, rem_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                byte_acc;
  logic                timed_out;

  // The strobes are decoded straight from the state so each lasts exactly
  // the one cycle spent in BUS_WR / BUS_RD, and the two can never overlap.
  assign oBUS_ADDR  = addr_q;
  assign oBUS_WDATA = wdata_q;
  assign oBUS_WR    = (state_q == S_BUS_WR);
  assign oBUS_RD    = (state_q == S_BUS_RD);
  assign oTxD_DATA  = tx_data_q;
  assign oTxD_Start = tx_start_q;
  assign oBUSY      = (state_q != S_IDLE);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      txbuf_q    <= '0;
      rem_q      <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      txbuf_q    <= txbuf_d;
      rem_q      <= rem_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    txbuf_d    = txbuf_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    byte_acc   = 1'b0;
    timed_out  = (timer_q == TMR_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (iRxD_Ready && (iRxD_DATA == OP_WR || iRxD_DATA == OP_RD)) begin
          byte_acc = 1'b1;
          is_wr_d  = (iRxD_DATA == OP_WR);
          cnt_d    = '0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        // A byte arriving on the last allowed cycle wins over the timeout.
        if (iRxD_Ready) begin
          byte_acc = 1'b1;
          for (int i = 0; i < NA; i++) begin
            if (cnt_q == 8'(i)) addr_d[8*i +: 8] = iRxD_DATA;
          end
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = is_wr_q ? S_WDATA : S_BUS_RD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (timed_out) begin
          state_d = S_IDLE;
        end
      end

      S_WDATA: begin
        if (iRxD_Ready) begin
          byte_acc = 1'b1;
          for (int i = 0; i < ND; i++) begin
            if (cnt_q == 8'(i)) wdata_d[8*i +: 8] = iRxD_DATA;
          end
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_BUS_WR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (timed_out) begin
          state_d = S_IDLE;
        end
      end

      S_BUS_WR: begin
        txbuf_d = DATA_W'(ACK_BYTE);
        rem_d   = 8'd1;
        state_d = S_TX_LOAD;
      end

      S_BUS_RD: begin
        state_d = S_WAIT_RD;
      end

      // Only entered the cycle after the read strobe, so a valid pulse that
      // coincides with the strobe itself is never seen here.
      S_WAIT_RD: begin
        if (iBUS_RDVALID) begin
          txbuf_d = iBUS_RDATA;
          rem_d   = RD_BYTES;
          state_d = S_TX_LOAD;
        end else if (timed_out) begin
          txbuf_d = DATA_W'(ERR_BYTE);
          rem_d   = 8'd1;
          state_d = S_TX_LOAD;
        end
      end

      S_TX_LOAD: begin
        tx_data_d  = txbuf_q[7:0];
        tx_start_d = 1'b1;
        state_d    = S_TX_WAIT;
      end

      S_TX_WAIT: begin
        if (iTxD_Done) begin
          tx_start_d = 1'b0;
          rem_d      = rem_q - 8'd1;
          txbuf_d    = txbuf_q >> 8;
          state_d    = S_TX_GAP;
        end
      end

      // Start stays low here for at least one cycle so the link re-arms.
      S_TX_GAP: begin
        state_d = (rem_q != 8'd0) ? S_TX_LOAD : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The timer restarts on any state change or accepted byte and only
    // runs while waiting on the host or the bus.
    if (state_d != state_q || byte_acc) begin
      timer_d = '0;
    end else if (state_q == S_ADDR || state_q == S_WDATA || state_q == S_WAIT_RD) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      timer_d = '0;
    end
  end

endmodule
